reg_writeback: RTL
==================

# reg_writeback

Register-file writeback unit: collects completed results from the ALU and load paths through valid/ready handshakes and buffers them in a small in-order queue. It drives the register file's single write port (write_enable / write_address / data_in) one write per cycle. It also publishes a pending-write scoreboard so decode can stall on registers with results still in flight. It sits between execute/memory and the register file, as the writer end of that write port.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- DW, 32, data width
- AW, 5, register address width
- MAX_ADDR, 23, highest architecturally backed register; writes above it are discarded
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- ld_valid  in  1  load result valid
- ld_ready  out  1  load result accepted when ld_valid && ld_ready
- ld_addr  in  AW  load destination register
- ld_data  in  DW  load result
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  ALU result accepted when alu_valid && alu_ready
- alu_addr  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- rf_we  out  1  register-file write enable, registered
- rf_waddr  out  AW  register-file write address, registered
- rf_wdata  out  DW  register-file write data, registered
- pending  out  32  bit i set while a write to register i is queued or staged
- count  out  $clog2(DEPTH)+1  queue occupancy
- fwd_addr  in  AW  bypass lookup address (WB_FWD_EN only)
- fwd_hit  out  1  pending write to fwd_addr exists (WB_FWD_EN only)
- fwd_data  out  DW  newest pending data for fwd_addr (WB_FWD_EN only)

## Operation
- Queue: in-order FIFO of {addr, data}; at most one enqueue and one dequeue per cycle.
- Arbitration: load has fixed priority. ld_ready = (count < DEPTH). alu_ready = (count < DEPTH) && !ld_valid. Neither ready depends on same-cycle dequeue.
- Address filter: an accepted result with addr > MAX_ADDR completes its handshake but is not enqueued, and does not affect pending or count.
- Drain: each cycle the queue is non-empty, the head is dequeued into the output stage: rf_we=1, rf_waddr/rf_wdata = head. If empty, rf_we=0; rf_waddr/rf_wdata hold their last values.
- Simultaneous enqueue and dequeue: count unchanged; full queue still refuses new input that cycle.
- Order: writes reach the register file in acceptance order; two writes to the same register both occur, later one last.
- pending: OR over valid queue entries plus the output stage when rf_we=1; combinational from state.
- Reset (any time, incl. mid-drain): queue emptied, count=0, rf_we=0, rf_waddr=0, rf_wdata=0, pending=0, ld_ready=alu_ready=1 after release. In-flight entries are lost.

## Timing
- Accept at edge N → entry queued after N → dequeued at edge N+1 → rf_we high during cycle N+1..N+2 (one cycle per entry).
- Back-to-back accepts yield back-to-back rf_we cycles; sustained throughput one write/cycle.
- ready, pending, count: functions of registered state only (no combinational valid→ready path except alu_ready on ld_valid).
- fwd_hit/fwd_data: combinational from fwd_addr and state, same cycle.

## Configuration
- WB_FWD_EN defined: fwd_* ports present. Match searches queue entries youngest-first, then the output stage (when rf_we=1); newest match wins. fwd_hit=0 and fwd_data=0 on miss or fwd_addr > MAX_ADDR.
- Undefined: fwd_* ports and lookup logic absent; all other behaviour identical.

## Structure
- Shared package wb_pkg: DEPTH, DW, AW, MAX_ADDR constants; wb_entry_t struct {addr, data}.
- One sub-module: wb_fifo (storage, read/write pointers with wrap, count, per-entry valid for pending/bypass scan). Arbitration, filter, output stage, scoreboard in reg_writeback.

## Test plan
- Single ALU result addr=5 data=0x1234 at edge N → rf_we=1, rf_waddr=5, rf_wdata=0x1234 in cycle after N+1; pending[5]=1 from after N until rf_we drops.
- ld_valid and alu_valid together (ld 7/0xAA, alu 8/0xBB) → load accepted first, alu_ready=0 that cycle; writes reach RF as reg7 then reg8.
- Hold rf path busy with 6 back-to-back ALU writes, DEPTH=4 → count never exceeds 4, alu_ready drops only at count=4, all 6 writes appear in order, no loss or duplicate.
- Write addr=30 data=0xDEAD → handshake completes, count stays 0, no rf_we, pending stays 0.
- WB_FWD_EN: queue reg3=0x11 then reg3=0x22, fwd_addr=3 → fwd_hit=1, fwd_data=0x22; after both drain → fwd_hit=0.
- Assert rst with 3 entries queued → rf_we, count, pending go 0 immediately; no further writes after release.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared constants and types for the register-file writeback unit.
//   DEPTH    - writeback queue entries (power of two, >= 2)
//   DW / AW  - data and register address widths
//   MAX_ADDR - highest architecturally backed register
//   wb_entry_t - one queued write {addr, data}
package wb_pkg;

  localparam int DEPTH    = 4;
  localparam int DW       = 32;
  localparam int AW       = 5;
  localparam int MAX_ADDR = 23;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [AW-1:0] MAX_ADDR_V = AW'(MAX_ADDR);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_entry_t;

  // True when the register exists in the physical register file.
  function automatic logic addr_backed(input logic [AW-1:0] a);
    return (a <= MAX_ADDR_V);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: in-order queue of pending register writes.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   push, wr_entry  - enqueue request (ignored when full)
//   pop             - dequeue request (ignored when empty)
//   head            - oldest entry
//   count           - occupancy
//   entry_addr/entry_valid - queue contents in age order, index 0 = oldest
//   entry_data      - matching data, only built when WB_FWD_EN is defined
module wb_fifo
  import wb_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  wb_entry_t                wr_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic [CW-1:0]            count,
  output logic [DEPTH-1:0][AW-1:0] entry_addr,
`ifdef WB_FWD_EN
  output logic [DEPTH-1:0][DW-1:0] entry_data,
`endif
  output logic [DEPTH-1:0]         entry_valid
);

  wb_entry_t [DEPTH-1:0] mem_r;
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  do_push_s;
  logic                  do_pop_s;

  assign do_push_s = push && (count_r < FULL_COUNT);
  assign do_pop_s  = pop && (count_r != {CW{1'b0}});

  // Storage, wrapping pointers and occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_r    <= '0;
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wr_entry;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

  // Age-ordered view of the queue for the scoreboard and bypass scan.
  always_comb begin
    entry_addr  = '0;
    entry_valid = {DEPTH{1'b0}};
`ifdef WB_FWD_EN
    entry_data  = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      entry_addr[k]  = mem_r[PW'(rd_ptr_r + PW'(k))].addr;
      entry_valid[k] = (CW'(k) < count_r);
`ifdef WB_FWD_EN
      entry_data[k]  = mem_r[PW'(rd_ptr_r + PW'(k))].data;
`endif
    end
  end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: collects ALU and load results, queues them in order and
// drives the register file's single write port one write per cycle.
// Optional macro WB_FWD_EN adds a same-cycle bypass lookup (fwd_* ports).
// Ports:
//   ld_valid/ld_ready/ld_addr/ld_data     - load result handshake (priority)
//   alu_valid/alu_ready/alu_addr/alu_data - ALU result handshake
//   rf_we/rf_waddr/rf_wdata               - registered register-file write
//   pending                               - registers with writes in flight
//   count                                 - queue occupancy
//   fwd_addr/fwd_hit/fwd_data             - bypass lookup (WB_FWD_EN only)
module reg_writeback
  import wb_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  input  logic          alu_valid,
  output logic          alu_ready,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic [31:0]   pending,
`ifdef WB_FWD_EN
  input  logic [AW-1:0] fwd_addr,
  output logic          fwd_hit,
  output logic [DW-1:0] fwd_data,
`endif
  output logic [CW-1:0] count
);

  logic                     not_full_s;
  logic                     ld_fire_s;
  logic                     alu_fire_s;
  logic                     push_s;
  logic                     pop_s;
  wb_entry_t                in_entry_s;
  wb_entry_t                head_s;
  logic [CW-1:0]            count_s;
  logic [DEPTH-1:0][AW-1:0] entry_addr_s;
  logic [DEPTH-1:0]         entry_valid_s;
  logic [31:0]              pending_s;
  logic                     rf_we_r;
  logic [AW-1:0]            rf_waddr_r;
  logic [DW-1:0]            rf_wdata_r;
`ifdef WB_FWD_EN
  logic [DEPTH-1:0][DW-1:0] entry_data_s;
  logic                     fwd_hit_s;
  logic [DW-1:0]            fwd_data_s;
`endif

  // Readiness looks at registered occupancy only; a same-cycle drain does
  // not open a slot. ALU yields to a valid load.
  assign not_full_s = (count_s < FULL_COUNT);
  assign ld_ready   = not_full_s;
  assign alu_ready  = not_full_s && !ld_valid;
  assign ld_fire_s  = ld_valid && ld_ready;
  assign alu_fire_s = alu_valid && alu_ready;
  assign pop_s      = (count_s != {CW{1'b0}});

  // Pick the accepted result; unbacked registers complete but are dropped.
  always_comb begin
    in_entry_s = '0;
    if (ld_fire_s) begin
      in_entry_s.addr = ld_addr;
      in_entry_s.data = ld_data;
    end else begin
      in_entry_s.addr = alu_addr;
      in_entry_s.data = alu_data;
    end
    push_s = (ld_fire_s || alu_fire_s) && addr_backed(in_entry_s.addr);
  end

  wb_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (push_s),
    .wr_entry    (in_entry_s),
    .pop         (pop_s),
    .head        (head_s),
    .count       (count_s),
    .entry_addr  (entry_addr_s),
`ifdef WB_FWD_EN
    .entry_data  (entry_data_s),
`endif
    .entry_valid (entry_valid_s)
  );

  // Output stage: drain the head into the register-file write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we_r    <= 1'b0;
      rf_waddr_r <= {AW{1'b0}};
      rf_wdata_r <= {DW{1'b0}};
    end else begin
      rf_we_r <= pop_s;
      if (pop_s) begin
        rf_waddr_r <= head_s.addr;
        rf_wdata_r <= head_s.data;
      end else begin
        rf_waddr_r <= rf_waddr_r;
        rf_wdata_r <= rf_wdata_r;
      end
    end
  end

  // Scoreboard: every queued entry plus the write currently on the port.
  always_comb begin
    pending_s = 32'h0000_0000;
    pending_s[rf_waddr_r] = rf_we_r;
    for (int k = 0; k < DEPTH; k++) begin
      pending_s[entry_addr_s[k]] = pending_s[entry_addr_s[k]] | entry_valid_s[k];
    end
  end

`ifdef WB_FWD_EN
  // Bypass scan from oldest (output stage) to youngest so the newest match wins.
  always_comb begin
    fwd_hit_s  = 1'b0;
    fwd_data_s = {DW{1'b0}};
    if (rf_we_r && (rf_waddr_r == fwd_addr)) begin
      fwd_hit_s  = 1'b1;
      fwd_data_s = rf_wdata_r;
    end else begin
      fwd_hit_s  = 1'b0;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (entry_valid_s[k] && (entry_addr_s[k] == fwd_addr)) begin
        fwd_hit_s  = 1'b1;
        fwd_data_s = entry_data_s[k];
      end else begin
        fwd_hit_s  = fwd_hit_s;
      end
    end
    if (!addr_backed(fwd_addr)) begin
      fwd_hit_s  = 1'b0;
      fwd_data_s = {DW{1'b0}};
    end else begin
      fwd_hit_s  = fwd_hit_s;
    end
  end

  assign fwd_hit  = fwd_hit_s;
  assign fwd_data = fwd_data_s;
`endif

  assign rf_we    = rf_we_r;
  assign rf_waddr = rf_waddr_r;
  assign rf_wdata = rf_wdata_r;
  assign pending  = pending_s;
  assign count    = count_s;

endmodule
